div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Front-end stage wrapped around the 32-bit multi-cycle divider.
- Accepts division requests on a valid/ready handshake and latches the operands.
- Drives the divider's reset/run controls, waits for its Ready, captures Quotient/Remainder, and presents them downstream on a valid/ready handshake.
- Handles divide-by-zero and divider timeout locally, without relying on the divider's output.

Parameters:
- TIMEOUT_CYCLES, 40: maximum cycles spent in WAIT before the request is aborted.
- ZERO_QUOT, 32'hFFFFFFFF: quotient returned on divide-by-zero.

Ports:
- clk  in  1  system clock; one clock domain, all logic rising-edge.
- Reset  in  1  synchronous, active-high reset.
- In_Valid  in  1  request valid.
- In_Ready  out  1  request accepted when In_Valid && In_Ready.
- In_Dividend  in  32  dividend.
- In_Divisor  in  32  divisor.
- In_Signed  in  1  signed request; used only with SIGNED_DIV_EN.
- Div_Dividend  out  32  operand to divider, held stable from CLEAR until DONE.
- Div_Divisor  out  32  operand to divider, held stable from CLEAR until DONE.
- Div_Reset  out  1  divider control reset, pulsed one cycle in CLEAR.
- Div_Run  out  1  divider start, pulsed one cycle in START.
- Div_Ready  in  1  divider done.
- Div_Quotient  in  32  divider quotient.
- Div_Remainder  in  32  divider remainder.
- Out_Valid  out  1  result valid.
- Out_Ready  in  1  downstream accepts.
- Out_Quotient  out  32  result quotient.
- Out_Remainder  out  32  result remainder.
- Out_DivZero  out  1  result flag: divisor was 0.
- Out_Timeout  out  1  result flag: divider never signalled Ready.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0 except In_Ready, which is 1.
  - Timeout counter clears.
  - Reset in any state, including mid-WAIT, abandons the request with no Out_Valid.
  - The divider is re-cleared by the next request's CLEAR.
- States: IDLE, CLEAR, START, WAIT, FIX, DONE.
- IDLE:
  - In_Ready=1.
  - On handshake, latch operands (and sign info).
  - If the divisor is 0: load Out_Quotient=ZERO_QUOT, Out_Remainder=dividend, Out_DivZero=1, and go to DONE. The divider is not launched.
  - Otherwise go to CLEAR.
- CLEAR: Div_Reset=1 for one cycle -> START.
- START: Div_Run=1 for one cycle; counter cleared -> WAIT.
- WAIT:
  - Counter increments each cycle.
  - Div_Ready is ignored in the first WAIT cycle, so a stale Ready cannot be captured.
  - On Div_Ready=1, capture Div_Quotient/Div_Remainder -> FIX.
  - If the counter reaches TIMEOUT_CYCLES first: Out_Quotient=0, Out_Remainder=0, Out_Timeout=1 -> DONE.
- FIX: apply sign correction (see Optional Feature); otherwise pass-through -> DONE.
- DONE:
  - Out_Valid=1; outputs and flags held stable.
  - On Out_Ready=1, drop Out_Valid, clear flags, and go to IDLE.
  - The next request can be accepted no earlier than the cycle after the output handshake (no overlap).
- In_Ready is 1 only in IDLE. In_Valid outside IDLE is ignored.
- Latency, measured from the request handshake in cycle T:
  - Normal request: Out_Valid rises at cycle R+2, where R is the first cycle Div_Ready is sampled high in WAIT.
  - Divide-by-zero: Out_Valid rises at T+1.
- Arithmetic is 32-bit; overflow wraps silently.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- When defined and In_Signed=1:
  - Operands sent to the divider are two's-complement magnitudes.
  - In FIX, the quotient is negated if the operand signs differ.
  - The remainder takes the dividend's sign.
  - -2^31 / -1 yields Q=32'h80000000, R=0 (wrap, no flag).
  - Divide-by-zero returns Q=ZERO_QUOT, R=original signed dividend.
- When undefined: In_Signed is ignored, all operations are unsigned, and FIX is a one-cycle pass-through (latency unchanged).

Test Plan:
- Unsigned 100/7, divider model Ready after 33 cycles: expect Div_Reset then Div_Run pulses, Out_Quotient=14, Out_Remainder=2, flags 0, Out_Valid two cycles after Ready.
- 7/0: expect no Div_Run, Out_Valid at T+1, Q=32'hFFFFFFFF, R=7, Out_DivZero=1.
- Backpressure: Out_Ready held low 5 cycles after 50/5: outputs stay Q=10, R=0 with Out_Valid=1 and In_Ready=0; a new In_Valid during this time is not accepted.
- Divider model never asserts Ready: Out_Timeout=1, Q=0, R=0 after TIMEOUT_CYCLES=40 WAIT cycles; a subsequent 9/2 completes with Q=4, R=1.
- Reset asserted mid-WAIT: next cycle all outputs 0, In_Ready=1, no Out_Valid ever seen for the aborted request; the next request completes normally.
- SIGNED_DIV_EN, In_Signed=1:
  - -100/7 gives Q=32'hFFFFFFF2, R=32'hFFFFFFFE.
  - 100/-7 gives Q=32'hFFFFFFF2, R=2.
  - 32'h80000000 / 32'hFFFFFFFF gives Q=32'h80000000, R=0.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: valid/ready front end for the 32-bit multi-cycle divider; define SIGNED_DIV_EN for signed requests
module div_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter logic [31:0] ZERO_QUOT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] In_Dividend,
  input  logic [31:0] In_Divisor,
  input  logic        In_Signed,
  output logic [31:0] Div_Dividend,
  output logic [31:0] Div_Divisor,
  output logic        Div_Reset,
  output logic        Div_Run,
  input  logic        Div_Ready,
  input  logic [31:0] Div_Quotient,
  input  logic [31:0] Div_Remainder,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_Quotient,
  output logic [31:0] Out_Remainder,
  output logic        Out_DivZero,
  output logic        Out_Timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic in_ready_q, in_ready_d, div_reset_q, div_reset_d, div_run_q, div_run_d;
  logic out_valid_q, out_valid_d, out_dz_q, out_dz_d, out_to_q, out_to_d;
  logic neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;
  logic [31:0] div_dividend_q, div_dividend_d, div_divisor_q, div_divisor_d;
  logic [31:0] out_quot_q, out_quot_d, out_rem_q, out_rem_d;
  logic neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
`ifdef SIGNED_DIV_EN
  assign neg_a = In_Signed & In_Dividend[31];
  assign neg_b = In_Signed & In_Divisor[31];
`else
  logic unused_signed;
  assign unused_signed = In_Signed;
  assign neg_a = 1'b0;
  assign neg_b = 1'b0;
`endif
  // the divider always sees magnitudes; the signs are reapplied in FIX
  assign mag_a = neg_a ? -In_Dividend : In_Dividend;
  assign mag_b = neg_b ? -In_Divisor : In_Divisor;
  // next-state and next-output logic; strobes are derived from the next state so they come straight off flops
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d = div_divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d = neg_rem_q;
    out_quot_d = out_quot_q;
    out_rem_d = out_rem_q;
    out_dz_d = out_dz_q;
    out_to_d = out_to_q;
    case (state_q)
      IDLE: if (In_Valid) begin
        div_dividend_d = mag_a;
        div_divisor_d = mag_b;
        neg_quot_d = neg_a ^ neg_b;
        neg_rem_d = neg_a;
        if (In_Divisor == '0) begin
          state_d = DONE;
          out_quot_d = ZERO_QUOT;
          out_rem_d = In_Dividend;
          out_dz_d = 1'b1;
        end else state_d = CLEAR;
      end
      CLEAR: state_d = START;
      START: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != '0 && Div_Ready) begin
          state_d = FIX;
          out_quot_d = Div_Quotient;
          out_rem_d = Div_Remainder;
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          out_quot_d = '0;
          out_rem_d = '0;
          out_to_d = 1'b1;
        end
      end
      FIX: begin
        state_d = DONE;
        out_quot_d = neg_quot_q ? -out_quot_q : out_quot_q;
        out_rem_d = neg_rem_q ? -out_rem_q : out_rem_q;
      end
      DONE: if (Out_Ready) begin
        state_d = IDLE;
        out_dz_d = 1'b0;
        out_to_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == IDLE;
    div_reset_d = state_d == CLEAR;
    div_run_d = state_d == START;
    out_valid_d = state_d == DONE;
  end
  // state, timeout counter and registered outputs
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      in_ready_q <= 1'b1;
      div_reset_q <= 1'b0;
      div_run_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_dz_q <= 1'b0;
      out_to_q <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q <= '0;
      out_quot_q <= '0;
      out_rem_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      in_ready_q <= in_ready_d;
      div_reset_q <= div_reset_d;
      div_run_q <= div_run_d;
      out_valid_q <= out_valid_d;
      out_dz_q <= out_dz_d;
      out_to_q <= out_to_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q <= neg_rem_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q <= div_divisor_d;
      out_quot_q <= out_quot_d;
      out_rem_q <= out_rem_d;
    end
  end
  assign In_Ready = in_ready_q;
  assign Div_Reset = div_reset_q;
  assign Div_Run = div_run_q;
  assign Div_Dividend = div_dividend_q;
  assign Div_Divisor = div_divisor_q;
  assign Out_Valid = out_valid_q;
  assign Out_Quotient = out_quot_q;
  assign Out_Remainder = out_rem_q;
  assign Out_DivZero = out_dz_q;
  assign Out_Timeout = out_to_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed requests against a divider model, checked every cycle by a timeline model
module tb_div_sequencer;
  localparam int TMO = 40;
  localparam logic [31:0] ZQ = 32'hFFFFFFFF;
  logic clk = 1'b0, Reset = 1'b1;
  logic In_Valid = 1'b0, In_Signed = 1'b0, Out_Ready = 1'b0;
  logic [31:0] In_Dividend = '0, In_Divisor = '0;
  logic In_Ready, Div_Reset, Div_Run, Div_Ready, Out_Valid, Out_DivZero, Out_Timeout;
  logic [31:0] Div_Dividend, Div_Divisor, Div_Quotient, Div_Remainder, Out_Quotient, Out_Remainder;
  int nvec = 0, nfail = 0, cyc = 0;
  bit chk_en = 0;
  div_sequencer #(.TIMEOUT_CYCLES(TMO), .ZERO_QUOT(ZQ)) dut (
    .clk(clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Dividend(In_Dividend), .In_Divisor(In_Divisor), .In_Signed(In_Signed),
    .Div_Dividend(Div_Dividend), .Div_Divisor(Div_Divisor), .Div_Reset(Div_Reset),
    .Div_Run(Div_Run), .Div_Ready(Div_Ready), .Div_Quotient(Div_Quotient),
    .Div_Remainder(Div_Remainder), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Quotient(Out_Quotient), .Out_Remainder(Out_Remainder),
    .Out_DivZero(Out_DivZero), .Out_Timeout(Out_Timeout));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // divider model: Ready rises dv_dly cycles after Run and stays up until the next Div_Reset
  int dv_dly = 1, dv_cnt = 0;
  bit dv_hang = 0;
  logic [31:0] dv_q = '0, dv_r = '0;
  always @(posedge clk) begin
    if (Div_Reset) dv_cnt <= 0;
    else if (Div_Run) begin
      dv_cnt <= dv_dly;
      dv_q <= Div_Divisor == 0 ? '1 : Div_Dividend / Div_Divisor;
      dv_r <= Div_Divisor == 0 ? Div_Dividend : Div_Dividend % Div_Divisor;
    end else if (dv_cnt > 1) dv_cnt <= dv_cnt - 1;
  end
  assign Div_Ready = !dv_hang && dv_cnt == 1;
  assign Div_Quotient = Div_Ready ? dv_q : 32'hDEADBEEF;
  assign Div_Remainder = Div_Ready ? dv_r : 32'hDEADBEEF;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic na, nb;
    logic [31:0] ma, mb, q, r;
`ifdef SIGNED_DIV_EN
    na = s & a[31];
    nb = s & b[31];
`else
    na = s & 1'b0;
    nb = 1'b0;
`endif
    ma = na ? -a : a;
    mb = nb ? -b : b;
    q = ma / mb;
    r = ma % mb;
    return {(na ^ nb) ? -q : q, na ? -r : r};
  endfunction

  // timeline model: handshake at cycle T, divider run at T+2, WAIT spans T+3..T+2+TMO,
  // Ready honoured from T+4, result visible two cycles after it is seen, timeout visible at T+3+TMO
  bit m_busy = 0, m_ov = 0, m_res = 0, m_dz = 0, m_to = 0;
  int m_t = 0, m_vc = 0;
  logic [31:0] m_q = '0, m_r = '0;
  always @(posedge clk) begin
    if (Reset) begin
      m_busy <= 0; m_ov <= 0; m_res <= 0; m_dz <= 0; m_to <= 0;
    end else if (m_ov) begin
      if (Out_Ready) begin
        m_ov <= 0; m_busy <= 0; m_dz <= 0; m_to <= 0;
      end
    end else if (m_busy) begin
      if (m_res) begin
        if (cyc + 1 == m_vc) m_ov <= 1;
      end else if (cyc - m_t >= 4 && Div_Ready) begin
        m_res <= 1; m_vc <= cyc + 2;
      end else if (cyc - m_t == TMO + 2) begin
        m_res <= 1; m_ov <= 1; m_q <= '0; m_r <= '0; m_to <= 1;
      end
    end else if (In_Valid) begin
      m_busy <= 1; m_t <= cyc;
      if (In_Divisor == 0) begin
        m_res <= 1; m_ov <= 1; m_dz <= 1; m_q <= ZQ; m_r <= In_Dividend;
      end else begin
        m_res <= 0;
        {m_q, m_r} <= ref_div(In_Dividend, In_Divisor, In_Signed);
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) if (chk_en) begin
    chk("in_ready", {31'd0, In_Ready}, {31'd0, !m_busy});
    chk("out_valid", {31'd0, Out_Valid}, {31'd0, m_ov});
    chk("div_reset", {31'd0, Div_Reset}, {31'd0, m_busy && !m_dz && cyc == m_t + 1});
    chk("div_run", {31'd0, Div_Run}, {31'd0, m_busy && !m_dz && cyc == m_t + 2});
    chk("divzero", {31'd0, Out_DivZero}, {31'd0, m_ov && m_dz});
    chk("timeout", {31'd0, Out_Timeout}, {31'd0, m_ov && m_to});
    if (m_ov) begin
      chk("quot", Out_Quotient, m_q);
      chk("rem", Out_Remainder, m_r);
    end
  end

  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic s, input int dly,
                         input bit hang, input int hold, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input logic eto, input int elat);
    int t0, n;
    @(posedge clk); #1;
    dv_dly = dly; dv_hang = hang;
    In_Valid = 1; In_Dividend = a; In_Divisor = b; In_Signed = s; t0 = cyc;
    @(posedge clk); #1;
    In_Valid = 0;
    n = 0;
    @(negedge clk);
    while (!Out_Valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(cyc - t0), 32'(elat));
    chk("lit_q", Out_Quotient, eq);
    chk("lit_r", Out_Remainder, er);
    chk("lit_dz", {31'd0, Out_DivZero}, {31'd0, edz});
    chk("lit_to", {31'd0, Out_Timeout}, {31'd0, eto});
    chk("model_q", m_q, eq);
    chk("model_r", m_r, er);
    if (hold > 0) begin
      In_Valid = 1; In_Dividend = 32'd99; In_Divisor = 32'd1;
      repeat (hold) @(posedge clk);
      #1;
      chk("bp_in_ready", {31'd0, In_Ready}, 32'd0);
      chk("bp_valid", {31'd0, Out_Valid}, 32'd1);
      chk("bp_q", Out_Quotient, eq);
      In_Valid = 0;
    end
    Out_Ready = 1;
    @(posedge clk); #1;
    Out_Ready = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    Reset = 0;
    chk("rst_in_ready", {31'd0, In_Ready}, 32'd1);
    chk("rst_valid", {31'd0, Out_Valid}, 32'd0);
    chk("rst_q", Out_Quotient, 32'd0);
    chk("rst_div_run", {31'd0, Div_Run}, 32'd0);
    chk_en = 1;
    run_req(32'd100, 32'd7, 1'b0, 33, 0, 0, 32'd14, 32'd2, 1'b0, 1'b0, 37);
    run_req(32'd7, 32'd0, 1'b0, 5, 0, 0, ZQ, 32'd7, 1'b1, 1'b0, 1);
    run_req(32'd50, 32'd5, 1'b0, 3, 0, 5, 32'd10, 32'd0, 1'b0, 1'b0, 7);
    run_req(32'd20, 32'd3, 1'b0, 3, 1, 0, 32'd0, 32'd0, 1'b0, 1'b1, TMO + 3);
    run_req(32'd9, 32'd2, 1'b0, 1, 0, 0, 32'd4, 32'd1, 1'b0, 1'b0, 6);
    run_req(32'd1000, 32'd10, 1'b0, TMO, 0, 0, 32'd100, 32'd0, 1'b0, 1'b0, TMO + 4);
    // abandon a request mid-WAIT while a stray request is offered
    @(posedge clk); #1;
    dv_dly = 30; dv_hang = 0;
    In_Valid = 1; In_Dividend = 32'd77; In_Divisor = 32'd3;
    @(posedge clk); #1;
    In_Dividend = 32'd5;
    repeat (10) @(posedge clk);
    #1;
    In_Valid = 0; Reset = 1;
    @(posedge clk); #1;
    Reset = 0;
    chk("mid_in_ready", {31'd0, In_Ready}, 32'd1);
    chk("mid_valid", {31'd0, Out_Valid}, 32'd0);
    chk("mid_q", Out_Quotient, 32'd0);
    chk("mid_div_dividend", Div_Dividend, 32'd0);
    repeat (40) @(posedge clk);
    run_req(32'd9, 32'd2, 1'b0, 5, 0, 0, 32'd4, 32'd1, 1'b0, 1'b0, 9);
`ifdef SIGNED_DIV_EN
    run_req(32'hFFFFFF9C, 32'd7, 1'b1, 2, 0, 0, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 6);
    run_req(32'd100, 32'hFFFFFFF9, 1'b1, 2, 0, 0, 32'hFFFFFFF2, 32'd2, 1'b0, 1'b0, 6);
    run_req(32'h80000000, 32'hFFFFFFFF, 1'b1, 2, 0, 0, 32'h80000000, 32'd0, 1'b0, 1'b0, 6);
    run_req(32'hFFFFFFFB, 32'd0, 1'b1, 2, 0, 0, ZQ, 32'hFFFFFFFB, 1'b1, 1'b0, 1);
`else
    run_req(32'hFFFFFF9C, 32'd7, 1'b1, 2, 0, 0, 32'd613566742, 32'd2, 1'b0, 1'b0, 6);
`endif
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected end before it", cyc);
    $fatal(1);
  end
endmodule
